button_conditioner: RTL

Conditions a raw mechanical push-button for the FPGA counter/control blocks. It synchronises and debounces the raw input and emits clean single-cycle event pulses: press, release, and hold-to-auto-repeat. step_pulse is the one-pulse-per-step strobe consumed directly by downstream up/down counters, so they need no edge detection of their own.

---
 rtl/button_conditioner.sv | 127 ++++++++++++
 1 files changed

// File: rtl/button_conditioner.sv
// Push-button conditioner: 2-flop synchroniser, counter debounce, registered
// press/release strobes and a hold-to-auto-repeat timer with a step strobe.
module button_conditioner #(
    parameter int CNT_WIDTH       = 20,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_RATE     = 5000000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    input  logic repeat_en,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic repeat_pulse,
    output logic step_pulse
);

    localparam longint CNT_TOP = (longint'(1) << CNT_WIDTH) - 1;

    // Cycle counts beyond the timer range are clamped to its maximum.
    function automatic logic [CNT_WIDTH-1:0] clamp(input longint v);
        return (v > CNT_TOP) ? CNT_WIDTH'(CNT_TOP) : CNT_WIDTH'(v);
    endfunction

    localparam logic [CNT_WIDTH-1:0] DB_LIMIT   = clamp(longint'(DEBOUNCE_CYCLES));
    localparam logic [CNT_WIDTH-1:0] DELAY_LAST = clamp(longint'(REPEAT_DELAY) - 1);
    localparam logic [CNT_WIDTH-1:0] RATE_LAST  = clamp(longint'(REPEAT_RATE) - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_SAT    = '1;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] DELAY  = 2'd1;
    localparam logic [1:0] REPEAT = 2'd2;
    localparam logic [1:0] HOLD   = 2'd3;

    logic                 sync1;
    logic                 btn_sync;
    logic [CNT_WIDTH-1:0] db_cnt;
    logic                 differ;
    logic                 db_done;
    logic                 rise;
    logic                 fall;

    logic [1:0]           state;
    logic [CNT_WIDTH-1:0] timer;
    logic                 expired;
    logic                 rep_fire;

    assign differ  = (btn_sync != btn_level);
    assign db_done = differ && (db_cnt >= DB_LIMIT);
    assign rise    = db_done && !btn_level;
    assign fall    = db_done && btn_level;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1         <= 1'b0;
            btn_sync      <= 1'b0;
            db_cnt        <= '0;
            btn_level     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            sync1    <= btn_raw;
            btn_sync <= sync1;
            if (!differ || db_done)
                db_cnt <= '0;
            else if (db_cnt != CNT_SAT)
                db_cnt <= db_cnt + 1'b1;
            if (db_done)
                btn_level <= !btn_level;
            press_pulse   <= rise;
            release_pulse <= fall;
        end
    end

    always_comb begin
        expired = 1'b0;
        case (state)
            DELAY:   expired = (timer >= DELAY_LAST);
            REPEAT:  expired = (timer >= RATE_LAST);
            default: expired = 1'b0;
        endcase
    end

    // A release on the expiry edge, or repeat_en low, suppresses the pulse.
    assign rep_fire = expired && repeat_en && !fall;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            timer        <= '0;
            repeat_pulse <= 1'b0;
            step_pulse   <= 1'b0;
        end else begin
            repeat_pulse <= rep_fire;
            step_pulse   <= rise | rep_fire;
            if (fall) begin
                state <= IDLE;
                timer <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (rise) begin
                            state <= repeat_en ? DELAY : HOLD;
                            timer <= '0;
                        end
                    end
                    DELAY, REPEAT: begin
                        if (!repeat_en) begin
                            state <= HOLD;
                            timer <= '0;
                        end else if (expired) begin
                            state <= REPEAT;
                            timer <= '0;
                        end else if (timer != CNT_SAT) begin
                            timer <= timer + 1'b1;
                        end
                    end
                    HOLD:    state <= HOLD;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
